// File: rtl/encode_sched_pkg.sv
// encode_sched_pkg
// Shared definitions for the encoder scheduler: source encoding,
// one-hot FSM state encoding and default port widths.
package encode_sched_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int INDEX_W_DEF = 10;

  localparam logic SRC_VARINT = 1'b0;
  localparam logic SRC_RAW    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SEL  = 3'b010,
    ST_SEND = 3'b100
  } state_t;

endpackage

// File: rtl/encode_sched_arb.sv
// rr_arb2
// Two-requester round-robin arbiter. Priority goes to the requester that
// was not granted last; the last-grant register only moves when the
// parent actually takes a grant (i_upd), which may also be a locked grant
// chosen outside this arbiter.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_req[1:0]     request: bit 0 varint, bit 1 raw
//   i_upd          a grant was taken this cycle
//   i_upd_src      source that was granted
//   o_gnt_vld      at least one requester present
//   o_gnt_src      round-robin winner
module rr_arb2
  import encode_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_src,
  output logic       o_gnt_vld,
  output logic       o_gnt_src
);

  logic r_last;

  // Reset to raw so varint wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= SRC_RAW;
    end else if (i_upd) begin
      r_last <= i_upd_src;
    end
  end

  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_src = SRC_VARINT;
    if (i_req == 2'b11) begin
      o_gnt_src = ~r_last;
    end else if (i_req == 2'b10) begin
      o_gnt_src = SRC_RAW;
    end
  end

endmodule

// File: rtl/encode_sched.sv
// encode_sched
// Schedules words from two show-ahead FIFOs (varint, raw) onto a single
// registered valid/ready encoder port. A source that has just issued a
// word keeps the grant while its head carries the same message index;
// otherwise the two sources are served round-robin.
// Ports:
//   clk, reset, enable                 clock, sync active-high reset, run enable
//   varint_out_*                       varint FIFO head / empty / pop
//   raw_data_out_*                     raw FIFO head / empty / pop
//   enc_valid/ready/src/data/index/wstrb  encoder port
//   words_sent                         wrapping handshake counter
module encode_sched
  import encode_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               varint_out_fifo_empty,
  input  logic [DATA_W-1:0]  varint_out_data,
  input  logic [INDEX_W-1:0] varint_out_index,
  output logic               varint_out_fifo_pop,
  input  logic               raw_data_out_fifo_empty,
  input  logic [DATA_W-1:0]  raw_data_out_data,
  input  logic [INDEX_W-1:0] raw_data_out_index,
  input  logic [3:0]         raw_data_out_wstrb,
  output logic               raw_data_out_fifo_pop,
  output logic               enc_valid,
  input  logic               enc_ready,
  output logic               enc_src,
  output logic [DATA_W-1:0]  enc_data,
  output logic [INDEX_W-1:0] enc_index,
  output logic [3:0]         enc_wstrb,
  output logic [15:0]        words_sent
);

  state_t r_state;
  state_t w_state_nxt;

  logic               r_lock_vld;
  logic               r_lock_src;
  logic [INDEX_W-1:0] r_lock_idx;

  logic               r_enc_valid;
  logic               r_enc_src;
  logic [DATA_W-1:0]  r_enc_data;
  logic [INDEX_W-1:0] r_enc_index;
  logic [3:0]         r_enc_wstrb;
  logic [15:0]        r_words_sent;

  logic w_v_hit;
  logic w_r_hit;
  logic w_lock_hit;
  logic w_arb_vld;
  logic w_arb_src;
  logic w_gnt_vld;
  logic w_gnt_src;
  logic w_take;

  // Lock holds only while the locked source still presents the same index.
  assign w_v_hit    = !varint_out_fifo_empty && (varint_out_index == r_lock_idx);
  assign w_r_hit    = !raw_data_out_fifo_empty && (raw_data_out_index == r_lock_idx);
  assign w_lock_hit = r_lock_vld && ((r_lock_src == SRC_VARINT) ? w_v_hit : w_r_hit);

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     ({!raw_data_out_fifo_empty, !varint_out_fifo_empty}),
    .i_upd     (w_take),
    .i_upd_src (w_gnt_src),
    .o_gnt_vld (w_arb_vld),
    .o_gnt_src (w_arb_src)
  );

  assign w_gnt_vld = w_lock_hit || w_arb_vld;
  assign w_gnt_src = w_lock_hit ? r_lock_src : w_arb_src;

  always_comb begin
    w_state_nxt           = r_state;
    w_take                = 1'b0;
    varint_out_fifo_pop   = 1'b0;
    raw_data_out_fifo_pop = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_SEL;
      end
      ST_SEL: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_gnt_vld) begin
          w_take      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (enc_ready) w_state_nxt = ST_SEL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Pops are combinational, so block them while reset is held.
    if (reset) w_take = 1'b0;
    varint_out_fifo_pop   = w_take && (w_gnt_src == SRC_VARINT);
    raw_data_out_fifo_pop = w_take && (w_gnt_src == SRC_RAW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lock_vld   <= 1'b0;
      r_lock_src   <= SRC_VARINT;
      r_lock_idx   <= '0;
      r_enc_valid  <= 1'b0;
      r_enc_src    <= SRC_VARINT;
      r_enc_data   <= '0;
      r_enc_index  <= '0;
      r_enc_wstrb  <= 4'h0;
      r_words_sent <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_enc_valid <= 1'b1;
        r_enc_src   <= w_gnt_src;
        r_lock_vld  <= 1'b1;
        r_lock_src  <= w_gnt_src;
        if (w_gnt_src == SRC_RAW) begin
          r_enc_data  <= raw_data_out_data;
          r_enc_index <= raw_data_out_index;
          r_enc_wstrb <= raw_data_out_wstrb;
          r_lock_idx  <= raw_data_out_index;
        end else begin
          r_enc_data  <= varint_out_data;
          r_enc_index <= varint_out_index;
          r_enc_wstrb <= 4'hF;
          r_lock_idx  <= varint_out_index;
        end
      end else if ((r_state == ST_SEL) && enable) begin
        // Evaluated in SEL with nothing taken: the lock condition failed.
        r_lock_vld <= 1'b0;
      end
      if ((r_state == ST_SEND) && enc_ready) begin
        r_enc_valid  <= 1'b0;
        r_words_sent <= r_words_sent + 16'd1;
      end
    end
  end

  assign enc_valid  = r_enc_valid;
  assign enc_src    = r_enc_src;
  assign enc_data   = r_enc_data;
  assign enc_index  = r_enc_index;
  assign enc_wstrb  = r_enc_wstrb;
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_encode_sched.sv
// tb_encode_sched
// Self-checking bench for encode_sched: queue-based FIFO models feed the
// DUT, a transaction-level scheduler model predicts pops and the encoder
// port every cycle, and directed scenarios pin the model with literal
// grant orders.
module tb_encode_sched;

  localparam int DW = 32;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          varint_out_fifo_empty = 1'b1;
  logic [DW-1:0] varint_out_data = '0;
  logic [IW-1:0] varint_out_index = '0;
  logic          varint_out_fifo_pop;
  logic          raw_data_out_fifo_empty = 1'b1;
  logic [DW-1:0] raw_data_out_data = '0;
  logic [IW-1:0] raw_data_out_index = '0;
  logic [3:0]    raw_data_out_wstrb = '0;
  logic          raw_data_out_fifo_pop;
  logic          enc_valid;
  logic          enc_ready = 1'b0;
  logic          enc_src;
  logic [DW-1:0] enc_data;
  logic [IW-1:0] enc_index;
  logic [3:0]    enc_wstrb;
  logic [15:0]   words_sent;

  always #5 clk = ~clk;

  encode_sched #(.DATA_W(DW), .INDEX_W(IW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .varint_out_fifo_empty   (varint_out_fifo_empty),
    .varint_out_data         (varint_out_data),
    .varint_out_index        (varint_out_index),
    .varint_out_fifo_pop     (varint_out_fifo_pop),
    .raw_data_out_fifo_empty (raw_data_out_fifo_empty),
    .raw_data_out_data       (raw_data_out_data),
    .raw_data_out_index      (raw_data_out_index),
    .raw_data_out_wstrb      (raw_data_out_wstrb),
    .raw_data_out_fifo_pop   (raw_data_out_fifo_pop),
    .enc_valid               (enc_valid),
    .enc_ready               (enc_ready),
    .enc_src                 (enc_src),
    .enc_data                (enc_data),
    .enc_index               (enc_index),
    .enc_wstrb               (enc_wstrb),
    .words_sent              (words_sent)
  );

  typedef struct {
    logic [31:0] d;
    logic [9:0]  i;
    logic [3:0]  s;
  } ent_t;

  ent_t qv[$];
  ent_t qr[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit c_reset = 1'b1, c_enable = 1'b0, c_ready = 1'b0;
  bit rnd_ready = 1'b0, rnd_enable = 1'b0, rnd_push = 1'b0, rnd_reset = 1'b0;
  int cur_vi = 1021, cur_ri = 1019;

  // Scheduler model: phase 0 idle, 1 choosing, 2 offering a word.
  int          m_phase = 0;
  bit          m_lockv = 1'b0;
  int          m_locks = 0;
  int          m_locki = 0;
  int          m_last  = 1;
  bit          m_valid = 1'b0;
  int          m_src   = 0;
  logic [31:0] m_data  = '0;
  int          m_idx   = 0;
  int          m_wstrb = 0;
  int          m_words = 0;

  int ml_src[$], ml_idx[$], ml_cyc[$];
  int dl_src[$], dl_idx[$], dl_ws[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Which source the scheduler must pick given the current FIFO heads; -1 none.
  function automatic int m_grant();
    bit ve = (qv.size() == 0);
    bit re = (qr.size() == 0);
    if (m_lockv) begin
      if (m_locks == 0 && !ve && int'(qv[0].i) == m_locki) return 0;
      if (m_locks == 1 && !re && int'(qr[0].i) == m_locki) return 1;
    end
    if (!ve && !re) return (m_last == 0) ? 1 : 0;
    if (!ve) return 0;
    if (!re) return 1;
    return -1;
  endfunction

  task automatic model_update();
    int   g;
    ent_t e;
    if (reset) begin
      m_phase = 0; m_lockv = 0; m_locks = 0; m_locki = 0; m_last = 1;
      m_valid = 0; m_src = 0; m_data = '0; m_idx = 0; m_wstrb = 0; m_words = 0;
      return;
    end
    case (m_phase)
      0: if (enable) m_phase = 1;
      1: begin
        if (!enable) begin
          m_phase = 0;
        end else begin
          g = m_grant();
          if (g >= 0) begin
            if (g == 0) begin
              e = qv.pop_front();
              m_wstrb = 15;
            end else begin
              e = qr.pop_front();
              m_wstrb = int'(e.s);
            end
            m_src = g; m_data = e.d; m_idx = int'(e.i);
            m_lockv = 1; m_locks = g; m_locki = int'(e.i); m_last = g;
            m_valid = 1; m_phase = 2;
            ml_src.push_back(g); ml_idx.push_back(int'(e.i)); ml_cyc.push_back(cyc);
          end else begin
            m_lockv = 0;
          end
        end
      end
      default: if (enc_ready) begin
        m_words = (m_words + 1) % 65536;
        m_valid = 0;
        m_phase = 1;
      end
    endcase
  endtask

  task automatic push_word(input int src, input logic [31:0] d, input int idx, input int s);
    ent_t e;
    e.d = d;
    e.i = 10'(idx);
    e.s = 4'(s);
    if (src == 0) qv.push_back(e); else qr.push_back(e);
  endtask

  task automatic drive();
    reset     = c_reset || (rnd_reset && $urandom_range(0, 599) == 0);
    enable    = rnd_enable ? ($urandom_range(0, 7) != 0) : c_enable;
    enc_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : c_ready;
    varint_out_fifo_empty = (qv.size() == 0);
    if (qv.size() != 0) begin
      varint_out_data = qv[0].d; varint_out_index = qv[0].i;
    end else begin
      varint_out_data = $urandom; varint_out_index = 10'($urandom_range(0, 1023));
    end
    raw_data_out_fifo_empty = (qr.size() == 0);
    if (qr.size() != 0) begin
      raw_data_out_data = qr[0].d; raw_data_out_index = qr[0].i; raw_data_out_wstrb = qr[0].s;
    end else begin
      raw_data_out_data = $urandom; raw_data_out_index = 10'($urandom_range(0, 1023));
      raw_data_out_wstrb = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic compare();
    int g = m_grant();
    bit take = (m_phase == 1) && enable && !reset && (g >= 0);
    chk("pop_varint", 64'(varint_out_fifo_pop), 64'(take && g == 0));
    chk("pop_raw", 64'(raw_data_out_fifo_pop), 64'(take && g == 1));
    chk("pop_varint_empty", 64'(varint_out_fifo_pop & varint_out_fifo_empty), 64'd0);
    chk("pop_raw_empty", 64'(raw_data_out_fifo_pop & raw_data_out_fifo_empty), 64'd0);
    chk("enc_valid", 64'(enc_valid), 64'(m_valid));
    chk("enc_src", 64'(enc_src), 64'(m_src));
    chk("enc_data", 64'(enc_data), 64'(m_data));
    chk("enc_index", 64'(enc_index), 64'(m_idx));
    chk("enc_wstrb", 64'(enc_wstrb), 64'(m_wstrb));
    chk("words_sent", 64'(words_sent), 64'(m_words));
    if (enc_valid && enc_ready && !reset) begin
      dl_src.push_back(int'(enc_src)); dl_idx.push_back(int'(enc_index)); dl_ws.push_back(int'(enc_wstrb));
    end
  endtask

  task automatic rand_pushes();
    if (qv.size() < 6 && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 2) == 0) cur_vi = (cur_vi + 1) % 1024;
      push_word(0, $urandom, cur_vi, $urandom_range(0, 15));
    end
    if (qr.size() < 6 && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 2) == 0) cur_ri = (cur_ri + 1) % 1024;
      push_word(1, $urandom, cur_ri, $urandom_range(0, 15));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    if (rnd_push) rand_pushes();
    drive();
    @(negedge clk);
    compare();
  endtask

  task automatic start_scn();
    qv.delete(); qr.delete();
    ml_src.delete(); ml_idx.delete(); ml_cyc.delete();
    dl_src.delete(); dl_idx.delete(); dl_ws.delete();
    rnd_ready = 0; rnd_enable = 0; rnd_push = 0; rnd_reset = 0;
    c_enable = 0; c_ready = 1; c_reset = 1;
    drive();
    step(); step();
    c_reset = 0;
    drive();
    step();
    chk("rst_valid", 64'(enc_valid), 64'd0);
    chk("rst_words", 64'(words_sent), 64'd0);
    chk("rst_data", 64'(enc_data), 64'd0);
    chk("rst_wstrb", 64'(enc_wstrb), 64'd0);
  endtask

  task automatic check_log(input string nm, input int es[$], input int ei[$]);
    chk({nm, "_model_count"}, 64'(ml_src.size()), 64'(es.size()));
    chk({nm, "_dut_count"}, 64'(dl_src.size()), 64'(es.size()));
    for (int k = 0; k < es.size(); k++) begin
      if (k < ml_src.size()) begin
        chk({nm, "_model_src"}, 64'(ml_src[k]), 64'(es[k]));
        chk({nm, "_model_idx"}, 64'(ml_idx[k]), 64'(ei[k]));
      end
      if (k < dl_src.size()) begin
        chk({nm, "_dut_src"}, 64'(dl_src[k]), 64'(es[k]));
        chk({nm, "_dut_idx"}, 64'(dl_idx[k]), 64'(ei[k]));
      end
    end
  endtask

  initial begin
    int es[$];
    int ei[$];

    // Varint only, index 5, always ready.
    start_scn();
    for (int k = 0; k < 3; k++) push_word(0, 32'h1000 + k, 5, 3);
    c_enable = 1; drive();
    repeat (10) step();
    es = '{0, 0, 0}; ei = '{5, 5, 5};
    check_log("varint_only", es, ei);
    chk("varint_only_words", 64'(words_sent), 64'd3);
    for (int k = 0; k < dl_ws.size(); k++) chk("varint_only_wstrb", 64'(dl_ws[k]), 64'hF);
    for (int k = 1; k < ml_cyc.size(); k++) chk("pop_spacing", 64'(ml_cyc[k] - ml_cyc[k-1]), 64'd2);

    // Both sources, changing indices: strict alternation, varint first.
    start_scn();
    for (int k = 0; k < 3; k++) begin
      push_word(0, $urandom, 1 + k, 0);
      push_word(1, $urandom, 10 + k, 4'h3);
    end
    c_enable = 1; drive();
    repeat (16) step();
    es = '{0, 1, 0, 1, 0, 1}; ei = '{1, 10, 2, 11, 3, 12};
    check_log("alternate", es, ei);

    // Message lock.
    start_scn();
    push_word(0, $urandom, 7, 0); push_word(0, $urandom, 7, 0); push_word(0, $urandom, 8, 0);
    push_word(1, $urandom, 7, 4'h5);
    c_enable = 1; drive();
    repeat (12) step();
    es = '{0, 0, 1, 0}; ei = '{7, 7, 7, 8};
    check_log("lock", es, ei);

    // Backpressure hold.
    start_scn();
    push_word(0, 32'hDEADBEEF, 3, 0); push_word(0, 32'h12345678, 3, 0);
    c_enable = 1; c_ready = 0; drive();
    step(); step();
    repeat (10) begin
      step();
      chk("hold_valid", 64'(enc_valid), 64'd1);
      chk("hold_data", 64'(enc_data), 64'hDEADBEEF);
      chk("hold_pop", 64'(varint_out_fifo_pop | raw_data_out_fifo_pop), 64'd0);
      chk("hold_words", 64'(words_sent), 64'd0);
    end
    c_ready = 1; drive();
    step();
    chk("hold_release_words", 64'(words_sent), 64'd1);

    // Index wrap 1023 -> 0 on raw drops the lock.
    start_scn();
    push_word(0, $urandom, 2, 0); push_word(0, $urandom, 4, 0);
    push_word(1, $urandom, 1023, 4'h1); push_word(1, $urandom, 0, 4'h2);
    c_enable = 1; drive();
    repeat (12) step();
    es = '{0, 1, 0, 1}; ei = '{2, 1023, 4, 0};
    check_log("wrap", es, ei);

    // Reset while offering a word.
    start_scn();
    push_word(0, $urandom, 9, 0); push_word(0, $urandom, 9, 0);
    c_enable = 1; drive();
    step(); step(); step();
    c_ready = 0; drive();
    step(); step();
    chk("send_valid_pre", 64'(enc_valid), 64'd1);
    chk("send_words_pre", 64'(words_sent), 64'd1);
    c_reset = 1; drive();
    step();
    chk("rst_in_send_valid", 64'(enc_valid), 64'd0);
    chk("rst_in_send_words", 64'(words_sent), 64'd0);
    chk("rst_in_send_pop", 64'(varint_out_fifo_pop | raw_data_out_fifo_pop), 64'd0);
    c_reset = 0; drive();
    step();

    // Random traffic with index walks, backpressure, enable toggles, rare resets.
    start_scn();
    rnd_ready = 1; rnd_enable = 1; rnd_push = 1; rnd_reset = 1;
    drive();
    repeat (5000) step();
    rnd_reset = 0; rnd_push = 0; rnd_enable = 0; c_enable = 1; rnd_ready = 0; c_ready = 1;
    drive();
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encode_sched.md
ENCODE_SCHED -- requirements
Module: encode_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of both input FIFOs and the encoder port.
REQ-002 SHALL have parameter INDEX_W, default 10, width of the message index tag.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  scheduling permitted when 1.
REQ-006 varint_out_fifo_empty  in  1; varint_out_data  in  DATA_W; varint_out_index  in  INDEX_W  show-ahead head of varint FIFO.
REQ-007 varint_out_fifo_pop  out  1  single-cycle pop strobe.
REQ-008 raw_data_out_fifo_empty  in  1; raw_data_out_data  in  DATA_W; raw_data_out_index  in  INDEX_W; raw_data_out_wstrb  in  4  show-ahead head of raw FIFO.
REQ-009 raw_data_out_fifo_pop  out  1  single-cycle pop strobe.
REQ-010 enc_valid  out  1; enc_ready  in  1; enc_src  out  1 (0 varint, 1 raw); enc_data  out  DATA_W; enc_index  out  INDEX_W; enc_wstrb  out  4  registered encoder port.
REQ-011 words_sent  out  16  count of encoder handshakes, wraps.

Function
REQ-012 SHALL implement states IDLE, SEL, SEND.
REQ-013 IDLE: outputs quiet; -> SEL when enable=1.
REQ-014 SEL: if enable=0 -> IDLE; else choose a source per REQ-016..018; if a source is chosen, assert its pop for exactly that cycle, register head data/index (wstrb = 4'hF for varint, head wstrb for raw) and source into enc_* outputs, -> SEND; if none eligible, stay in SEL.
REQ-015 SEND: enc_valid=1, enc_* stable; on enc_ready=1 increment words_sent, -> SEL; else stay. enable=0 in SEND SHALL NOT abort the transfer.
REQ-016 Message lock: after issuing a word, the scheduler holds lock on that source and index; in SEL the locked source SHALL be chosen if non-empty and its head index equals the locked index.
REQ-017 Lock release: the lock SHALL drop when the locked source is empty or its head index differs from the locked index.
REQ-018 Without lock: round-robin, priority to the source not last granted; both non-empty -> other source wins; one non-empty -> that one; after reset varint has priority.
REQ-019 Pop SHALL never be asserted while the corresponding empty=1; at most one pop per cycle; no pop in IDLE or SEND.
REQ-020 Latency: head visible in SEL at cycle N -> pop at N, enc_valid at N+1; maximum throughput one word per 2 cycles.
REQ-021 Index comparison SHALL be exact equality on INDEX_W bits; index wrap 1023->0 counts as a change.
REQ-022 words_sent SHALL wrap 16'hFFFF->0.

Reset
REQ-023 reset=1 SHALL force state IDLE, enc_valid=0, both pops 0, enc_src=0, enc_data=0, enc_index=0, enc_wstrb=0, words_sent=0, lock cleared, last-grant=raw (varint priority).
REQ-024 reset during SEND SHALL drop enc_valid next edge; the in-flight word is discarded.

Structure
REQ-025 Shared package SHALL hold source encoding (SRC_VARINT=0, SRC_RAW=1), state encoding (one-hot), default widths.
REQ-026 A sub-module rr_arb2 (2-requester round-robin with last-grant register, advances only on grant) SHALL implement REQ-018.

Verification
REQ-027 Varint-only: 3 words index 5, enc_ready=1 -> 3 transfers, src=0, wstrb=4'hF, index 5, words_sent=3, pop spacing 2 cycles.
REQ-028 Both non-empty, different index, after reset -> varint first, raw second, alternating while unlocked.
REQ-029 Lock: varint heads index 7,7,8; raw head index 7 -> varint 7, varint 7, then raw 7, then varint 8.
REQ-030 Backpressure: enc_ready=0 for 10 cycles -> enc_valid and enc_data 32'hDEADBEEF held, no pops, words_sent unchanged.
REQ-031 Index wrap: head indices 1023 then 0 on raw with varint non-empty -> lock drops after 1023, varint granted.
REQ-032 Reset asserted in SEND -> next cycle enc_valid=0, words_sent=0, no pop.
